spi_controller: RTL and testbench

- SPI mode-0 initiator that issues 16-bit register-write frames to the on-chip SPI register peripheral over sclk/copi/ncs. This is the other end of the peripheral's serial interface.
- Takes a parallel request (address, data) through a valid/ready handshake and serialises it MSB first. Pulses done when the frame completes.
- Used as an on-chip config master for self-test and loopback, and as a bench driver.

---
 rtl/spi_ctrl_pkg.sv | 22 ++
 rtl/spi_half_tick.sv | 37 +++
 rtl/spi_controller.sv | 129 ++++++++++++
 tb/tb_spi_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-write initiator: frame layout,
// peripheral register map and controller state encoding.
package spi_ctrl_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam logic        RW_WRITE = 1'b1;

  localparam logic [6:0] EN_OUT_LO = 7'h00;
  localparam logic [6:0] EN_OUT_HI = 7'h01;
  localparam logic [6:0] EN_PWM_LO = 7'h02;
  localparam logic [6:0] EN_PWM_HI = 7'h03;
  localparam logic [6:0] PWM_DUTY  = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer for the SPI initiator: counts 0..CLK_DIV-1 while enabled
// and flags the last cycle of each half-period. Cleared when a frame starts.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator issuing {rw, addr, data} frames MSB first.
// Define SPI_CONTROLLER_READ_EN to enable read frames sampled on cipo.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo
);

  localparam int unsigned FW = 1 + ADDR_W + DATA_W;
  localparam int unsigned BW = $clog2(FW);
  localparam logic [BW-1:0] BIT_MSB   = BW'(FW - 1);
  localparam logic [BW-1:0] DATA_MSB  = BW'(DATA_W - 1);

  logic [FW-1:0] frame;

`ifdef SPI_CONTROLLER_READ_EN
  localparam bit RD_EN = 1'b1;
  assign frame = req_rw ? {RW_WRITE, req_addr, req_data}
                        : {~RW_WRITE, req_addr, {DATA_W{1'b0}}};
`else
  localparam bit RD_EN = 1'b0;
  logic unused_rw;
  assign unused_rw = req_rw;
  assign frame = {RW_WRITE, req_addr, req_data};
`endif

  state_e            state_q;
  logic [FW-1:0]     shreg_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] rdsh_q, rd_q;
  logic              rw_q, ncs_q, sclk_q, copi_q, done_q, ready_q;
  logic              accept, tick;

  assign accept = req_valid && ready_q;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (accept),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      rdsh_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b1;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          shreg_q <= frame;
          rw_q    <= frame[FW-1];
          bit_q   <= BIT_MSB;
          copi_q  <= frame[FW-1];
          ncs_q   <= 1'b0;
          ready_q <= 1'b0;
          state_q <= SETUP;
        end
        SETUP: if (tick) begin
          sclk_q  <= 1'b1;
          state_q <= SHIFT_HI;
          if (RD_EN && bit_q <= DATA_MSB) rdsh_q <= {rdsh_q[DATA_W-2:0], cipo};
        end
        SHIFT_HI: if (tick) begin
          sclk_q  <= 1'b0;
          state_q <= SHIFT_LO;
          // Bit 0 is held through its low phase; only earlier bits advance here.
          if (bit_q != '0) begin
            copi_q  <= shreg_q[FW-2];
            shreg_q <= shreg_q << 1;
          end
        end
        SHIFT_LO: if (tick) begin
          if (bit_q == '0) begin
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            state_q <= GAP;
          end else begin
            bit_q   <= bit_q - 1'b1;
            sclk_q  <= 1'b1;
            state_q <= SHIFT_HI;
            if (RD_EN && (bit_q - 1'b1) <= DATA_MSB) rdsh_q <= {rdsh_q[DATA_W-2:0], cipo};
          end
        end
        GAP: if (tick) begin
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (RD_EN && !rw_q) rd_q <= rdsh_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign rd_data   = rd_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: cycle-offset model of the frame
// waveform, a behavioural register peripheral on the SPI pins, directed tests.
module tb_spi_controller;
  import spi_ctrl_pkg::*;

  localparam int C      = 4;
  localparam int LOW    = 33 * C;
  localparam int DONE_K = 34 * C + 1;

  logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_rw = 1'b1, cipo = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, done, sclk, copi, ncs;
  logic [7:0] rd_data;

  spi_controller #(.CLK_DIV(C), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .done(done),
    .rd_data(rd_data), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: position k within the frame (k=1 is the cycle after the accept edge).
  bit         m_busy = 0, m_done = 0, chk_en = 0;
  int         m_k = 0, m_acc = 0, m_dones = 0;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_rd = '0, rd_ret = 8'hA5;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_rd = '0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == DONE_K) begin
        m_busy = 0; m_done = 1; m_dones++;
        if (!m_frame[15]) m_rd = rd_ret;
      end
    end else begin
      m_done = 0;
      if (req_valid) begin
        m_busy = 1; m_k = 1; m_acc++;
`ifdef SPI_CONTROLLER_READ_EN
        m_frame = req_rw ? {1'b1, req_addr, req_data} : {1'b0, req_addr, 8'h00};
`else
        m_frame = {1'b1, req_addr, req_data};
`endif
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic e_ncs, e_sclk, e_copi, e_rdy, e_done;
    int idx;
    if (chk_en) begin
      if (m_busy) begin
        e_rdy  = 1'b0;
        e_done = 1'b0;
        e_ncs  = (m_k > LOW);
        e_sclk = (m_k > C) && (m_k <= LOW) && (((m_k - C - 1) / C) % 2 == 0);
        idx    = (m_k - 1) / (2 * C);
        if (idx > 15) idx = 15;
        e_copi = (m_k <= LOW) ? m_frame[15 - idx] : 1'b0;
      end else begin
        e_rdy = 1'b1; e_done = m_done; e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0;
      end
      chk("req_ready", req_ready, e_rdy);
      chk("done", done, e_done);
      chk("ncs", ncs, e_ncs);
      chk("sclk", sclk, e_sclk);
      chk("copi", copi, e_copi);
      chk("rd_data", rd_data, m_rd);
    end
  end

  // Behavioural register peripheral on the SPI pins.
  logic [7:0]  preg [0:127];
  logic [15:0] psh = '0, last_word = '0;
  int          pcnt = 0;
  always @(posedge sclk) if (!ncs) begin psh = {psh[14:0], copi}; pcnt++; end
  always @(negedge ncs) pcnt = 0;
  always @(posedge ncs) if (pcnt == 16) begin
    last_word = psh;
    if (psh[15]) preg[psh[14:8]] = psh[7:0];
  end
  always @(negedge clk) cipo = (pcnt >= 8 && pcnt < 16) ? rd_ret[15 - pcnt] : 1'b0;

  // Timing measurements taken from the DUT pins.
  int cyc = 0, acc_seen = 0, acc_edge = 0, lat = 0, lowrun = 0, hirun = 0, last_low = 0;
  bit was_frame = 0;
  int gaps[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (m_acc != acc_seen) begin acc_seen = m_acc; acc_edge = cyc; end
    if (done === 1'b1) lat = cyc - acc_edge + 1;
    if (ncs === 1'b0) begin
      if (was_frame && hirun > 0) gaps.push_back(hirun);
      hirun = 0; lowrun++; was_frame = 1;
    end else begin
      if (lowrun > 0) last_low = lowrun;
      lowrun = 0; hirun++;
    end
  end

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
    if (!ok) chk(name, 0, 1);
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, input bit wd);
    int acc0 = m_acc;
    bit ok = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_acc != acc0) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
    if (wd) wait_done("done_timeout");
  endtask

  initial begin
    int n, prev;
    bit cleared, ok;
    for (int i = 0; i < 128; i++) preg[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs, 1); chk("rst_sclk", sclk, 0); chk("rst_copi", copi, 0);
    chk("rst_done", done, 0); chk("rst_rd_data", rd_data, 0); chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    chk_en = 1;
    @(negedge clk);

    send(1'b1, EN_OUT_LO, 8'hF0, 1); @(negedge clk);
    chk("t1_word", last_word, 16'h80F0);
    chk("t1_ncs_low", last_low, 132);
    chk("t1_latency", lat, 137);

    send(1'b1, PWM_DUTY, 8'h80, 1);
    send(1'b1, EN_PWM_LO, 8'h01, 1); @(negedge clk);
    chk("t2_pwm_duty", preg[PWM_DUTY], 8'h80);
    chk("t2_en_pwm_lo", preg[EN_PWM_LO], 8'h01);

    // Three requests with req_valid held high throughout.
    n = 0; prev = m_acc; cleared = 0;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h05; req_data = 8'h11;
    for (int i = 0; i < 1000 && n < 3; i++) begin
      @(negedge clk);
      if (n >= 1 && !cleared) begin gaps.delete(); cleared = 1; end
      if (m_acc != prev) begin
        prev = m_acc; n++;
        req_addr = req_addr + 7'd1; req_data = req_data + 8'h11;
        if (n == 3) req_valid = 1'b0;
      end
    end
    chk("t3_accepts", n, 3);
    wait_done("t3_done_timeout"); @(negedge clk);
    chk("t3_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) begin chk("t3_gap0", gaps[0], 5); chk("t3_gap1", gaps[1], 5); end
    chk("t3_reg5", preg[5], 8'h11); chk("t3_reg6", preg[6], 8'h22); chk("t3_reg7", preg[7], 8'h33);

    // Reset during bit 7 of a frame.
    send(1'b1, EN_OUT_HI, 8'h3C, 0);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_busy && m_k >= 16 * C + 3) ok = 1;
    end
    rst_n = 1'b0; @(negedge clk);
    chk("t4_ncs", ncs, 1); chk("t4_sclk", sclk, 0);
    rst_n = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("t4_reg_untouched", preg[EN_OUT_HI], 8'h00);
    send(1'b1, EN_OUT_HI, 8'h3C, 1); @(negedge clk);
    chk("t4_reg_after", preg[EN_OUT_HI], 8'h3C);

    // Request fields change while the frame is in flight.
    send(1'b1, EN_PWM_HI, 8'h5A, 0);
    @(negedge clk); req_addr = 7'h7F; req_data = 8'hFF;
    wait_done("t5_done_timeout"); @(negedge clk);
    chk("t5_word", last_word, 16'h835A);
    chk("t5_reg", preg[EN_PWM_HI], 8'h5A);

    send(1'b0, EN_PWM_HI, 8'h77, 1); @(negedge clk);
`ifdef SPI_CONTROLLER_READ_EN
    chk("t6_word", last_word, 16'h0300);
    chk("t6_rd_data", rd_data, 8'hA5);
`else
    chk("t6_word", last_word, 16'h8377);
    chk("t6_rd_data", rd_data, 8'h00);
    chk("t6_reg", preg[EN_PWM_HI], 8'h77);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
